dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 tb/tb_dmem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single-ported data memory, with a
// saturating contention counter. Define DMEM_ARB_ROUND_ROBIN_EN for round-robin tie-break.
module dmem_arbiter #(
  parameter int Nloc = 64,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            m0_req,
  input  logic            m0_wr,
  input  logic [31:0]     m0_addr,
  input  logic [31:0]     m0_wdata,
  input  logic            m1_req,
  input  logic            m1_wr,
  input  logic [31:0]     m1_addr,
  input  logic [31:0]     m1_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [31:0]     m0_rdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [31:0]     m1_rdata,
  output logic            mem_wr,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_writedata,
  input  logic [31:0]     mem_readdata,
  output logic [CNTW-1:0] conflicts
);

  // Word select is addr[7:2], so the memory can never exceed 64 words.
  if (Nloc < 1 || Nloc > 64) begin : g_bad_nloc
    $error("dmem_arbiter: Nloc must be in 1..64");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  state_e          winner;
  logic            rvalid0_q, rvalid0_d;
  logic            rvalid1_q, rvalid1_d;
  logic [31:0]     rdata0_q, rdata0_d;
  logic [31:0]     rdata1_q, rdata1_d;
  logic [CNTW-1:0] conflicts_q, conflicts_d;
  logic            contention;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_served_q, last_served_d;

  assign winner = last_served_q ? SERVE0 : SERVE1;

  always_comb begin
    last_served_d = last_served_q;
    if (state_q == SERVE0) last_served_d = 1'b0;
    if (state_q == SERVE1) last_served_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_served_q <= 1'b1;
    else       last_served_q <= last_served_d;
  end
`else
  assign winner = SERVE0;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d       = IDLE;
    mem_wr        = 1'b0;
    mem_addr      = '0;
    mem_writedata = '0;
    contention    = 1'b0;
    unique case (state_q)
      IDLE: begin
        contention = m0_req && m1_req;
        if (m0_req && m1_req) state_d = winner;
        else if (m0_req)      state_d = SERVE0;
        else if (m1_req)      state_d = SERVE1;
      end
      SERVE0: begin
        mem_wr        = m0_wr;
        mem_addr      = m0_addr;
        mem_writedata = m0_wdata;
        contention    = m1_req;
        state_d       = m1_req ? SERVE1 : IDLE;
      end
      SERVE1: begin
        mem_wr        = m1_wr;
        mem_addr      = m1_addr;
        mem_writedata = m1_wdata;
        contention    = m0_req;
        state_d       = m0_req ? SERVE0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rvalid0_d   = (state_q == SERVE0) && !m0_wr;
    rvalid1_d   = (state_q == SERVE1) && !m1_wr;
    rdata0_d    = rvalid0_d ? mem_readdata : rdata0_q;
    rdata1_d    = rvalid1_d ? mem_readdata : rdata1_q;
    conflicts_d = (contention && (conflicts_q != '1)) ? conflicts_q + 1'b1 : conflicts_q;
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      conflicts_q <= '0;
    end else begin
      state_q     <= state_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign m0_gnt    = (state_q == SERVE0);
  assign m1_gnt    = (state_q == SERVE1);
  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign conflicts = conflicts_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// against a transaction-level model of grants, memory contents and counters.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req [2];
  logic        wr [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];

  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_wr;
  logic [31:0] mem_addr, mem_writedata, mem_readdata;
  logic [15:0] conflicts;

  logic        s_m0_gnt, s_m1_gnt, s_m0_rvalid, s_m1_rvalid;
  logic [31:0] s_m0_rdata, s_m1_rdata;
  logic        s_mem_wr;
  logic [31:0] s_mem_addr, s_mem_writedata, s_mem_readdata;
  logic [1:0]  s_conflicts;

  logic [31:0] mem [64];

  always #5 clk = ~clk;

  dmem_arbiter #(.Nloc(64), .CNTW(16)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m0_wr(wr[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m1_req(req[1]), .m1_wr(wr[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .conflicts(conflicts)
  );

  // Narrow-counter instance, only used to observe saturation.
  dmem_arbiter #(.Nloc(64), .CNTW(2)) dut_sat (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m0_wr(wr[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m1_req(req[1]), .m1_wr(wr[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m0_gnt(s_m0_gnt), .m0_rvalid(s_m0_rvalid), .m0_rdata(s_m0_rdata),
    .m1_gnt(s_m1_gnt), .m1_rvalid(s_m1_rvalid), .m1_rdata(s_m1_rdata),
    .mem_wr(s_mem_wr), .mem_addr(s_mem_addr), .mem_writedata(s_mem_writedata),
    .mem_readdata(s_mem_readdata), .conflicts(s_conflicts)
  );

  // Data memory: combinational read, write committed at the clock edge.
  assign mem_readdata   = mem[mem_addr[7:2]];
  assign s_mem_readdata = mem[s_mem_addr[7:2]];
  always @(posedge clk) if (mem_wr) mem[mem_addr[7:2]] <= mem_writedata;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: who is served this cycle (-1 none), what each port last read,
  // memory image, contention totals and the most recently served port.
  int          g;
  int          last_rr;
  longint      conf_total;
  logic [31:0] exp_mem [64];
  logic [31:0] exp_rd [2];
  logic        exp_rv [2];
  logic        done [2];

  function automatic logic [31:0] sat(input longint v, input int bits);
    longint mx = (longint'(1) << bits) - 1;
    return (v > mx) ? mx[31:0] : v[31:0];
  endfunction

  task automatic model_reset();
    g = -1;
    last_rr = 1;
    conf_total = 0;
    exp_rd = '{32'h0, 32'h0};
    exp_rv = '{1'b0, 1'b0};
    done = '{1'b0, 1'b0};
  endtask

  task automatic model_step();
    int w;
    bit cont;
    cont = (g < 0) ? (req[0] && req[1]) : req[1-g];
    if (cont) conf_total++;
    exp_rv = '{1'b0, 1'b0};
    done[0] = (g == 0);
    done[1] = (g == 1);
    if (g >= 0) begin
      if (wr[g]) exp_mem[addr[g][7:2]] = wdata[g];
      else begin
        exp_rv[g] = 1'b1;
        exp_rd[g] = exp_mem[addr[g][7:2]];
      end
      last_rr = g;
      g = req[1-g] ? 1 - g : -1;
    end else if (req[0] && req[1]) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      w = (last_rr == 1) ? 0 : 1;
`else
      w = 0;
`endif
      g = w;
    end else if (req[0]) g = 0;
    else if (req[1]) g = 1;
    else g = -1;
  endtask

  // One clock cycle: compare all outputs mid-cycle, advance the model, return just after the edge.
  task automatic cycle();
    @(negedge clk);
    check("m0_gnt", m0_gnt, g == 0);
    check("m1_gnt", m1_gnt, g == 1);
    check("mem_wr", mem_wr, (g >= 0) ? wr[g] : 1'b0);
    check("mem_addr", mem_addr, (g >= 0) ? addr[g] : 32'h0);
    check("mem_wdata", mem_writedata, (g >= 0) ? wdata[g] : 32'h0);
    check("m0_rvalid", m0_rvalid, exp_rv[0]);
    check("m1_rvalid", m1_rvalid, exp_rv[1]);
    check("m0_rdata", m0_rdata, exp_rd[0]);
    check("m1_rdata", m1_rdata, exp_rd[1]);
    check("conflicts", conflicts, sat(conf_total, 16));
    check("conflicts_sat", s_conflicts, sat(conf_total, 2));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    req[p] = r; wr[p] = w; addr[p] = a; wdata[p] = d;
  endtask

  int          cnt0, cnt1;
  logic        prev0, prev1;
  logic [31:0] saved;
  int          rate [2];

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'hA5A5_0000 | i;
      exp_mem[i] = 32'hA5A5_0000 | i;
    end
    for (int p = 0; p < 2; p++) drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_m1_gnt", m1_gnt, 0);
    check("rst_conflicts", conflicts, 0);
    check("rst_m0_rdata", m0_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;

    // Both ports request from reset-idle: port 0 first, then port 1.
    drive(0, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h0000_0008, 32'h0);
    cycle();
    check("t2_first_m0", m0_gnt, 1);
    check("t2_conflicts", conflicts, 1);
    cycle();
    check("t2_then_m1", m1_gnt, 1);
    req[0] = 1'b0;
    cycle();
    req[1] = 1'b0;
    cycle();
    // Second simultaneous request from IDLE: port 0 again.
    req[0] = 1'b1; req[1] = 1'b1;
    cycle();
    check("t6_second_m0", m0_gnt, 1);
    cycle();
    req[0] = 1'b0;
    cycle();
    req[1] = 1'b0;
    cycle();

    // Port 0 write then read of the same word.
    drive(0, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    cycle();
    check("t1_wr_gnt", m0_gnt, 1);
    cycle();
    drive(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    cycle();
    check("t1_rd_gnt", m0_gnt, 1);
    cycle();
    req[0] = 1'b0;
    check("t1_rvalid", m0_rvalid, 1);
    check("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
    cycle();
    check("t1_rvalid_pulse", m0_rvalid, 0);
    check("t1_rdata_hold", m0_rdata, 32'hDEAD_BEEF);

    // Both ports hold requests continuously: strict alternation.
    drive(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h0000_0014, 32'h0);
    cycle();
    cnt0 = 0; cnt1 = 0; prev0 = 1'b0; prev1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t3_no_b2b", (m0_gnt && prev0) || (m1_gnt && prev1), 0);
      cnt0 += m0_gnt; cnt1 += m1_gnt;
      prev0 = m0_gnt; prev1 = m1_gnt;
      cycle();
    end
    check("t3_cnt0", cnt0, 4);
    check("t3_cnt1", cnt1, 4);
    req[1] = 1'b0;
    cycle();
    req[0] = 1'b0;
    cycle();

    // Narrow counter has seen well over 3 contention edges.
    check("t5_sat", s_conflicts, 3);
    repeat (3) cycle();
    check("t5_sat_hold", s_conflicts, 3);

    // Reset pulse in the middle of a port-1 write cycle.
    saved = mem[8];
    drive(1, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_0005);
    cycle();
    check("t4_in_serve1", m1_gnt, 1);
    #1 reset = 1'b1;
    #1;
    check("t4_gnt_drop", m1_gnt, 0);
    check("t4_mem_wr", mem_wr, 0);
    check("t4_mem_addr", mem_addr, 0);
    check("t4_mem_wdata", mem_writedata, 0);
    check("t4_conflicts", conflicts, 0);
    check("t4_rdata", m0_rdata, 0);
    reset = 1'b0;
    req[1] = 1'b0;
    model_reset();
    cycle();
    cycle();
    check("t4_mem_unchanged", mem[8], saved);

    // Random traffic obeying the request protocol.
    for (int phase = 0; phase < 3; phase++) begin
      rate[0] = (phase == 1) ? 90 : 50;
      rate[1] = (phase == 2) ? 90 : 40;
      for (int c = 0; c < 600; c++) begin
        for (int p = 0; p < 2; p++) begin
          if (!(req[p] && !done[p])) begin
            if ($urandom_range(99) < rate[p])
              drive(p, 1'b1, 1'($urandom_range(1)),
                    {$urandom_range(255), 16'h0, 2'b00, 6'($urandom_range(15)), 2'b00},
                    $urandom);
            else req[p] = 1'b0;
          end
        end
        cycle();
      end
    end
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
